// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential 8x8 Vedic multiplier.
// Holds the FSM state type, datapath widths, the per-step shift table
// and the 2x2 Urdhva-Tiryagbhyam building block used by the 4x4 core.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned STEPS  = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PROD_W = 16;

    // Shift applied to the core product at steps 0..3 (4 bits per entry, step 0 in the LSBs)
    localparam logic [4*STEPS-1:0] SHIFT_TAB = {4'd8, 4'd4, 4'd4, 4'd0};

    // 2x2 vertical-and-crosswise product
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] p;
        logic       c1;
        p[0] = x[0] & y[0];
        p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1   = (x[1] & y[0]) & (x[0] & y[1]);
        p[2] = (x[1] & y[1]) ^ c1;
        p[3] = (x[1] & y[1]) & c1;
        return p;
    endfunction

endpackage

// File: rtl/Vedic4x4_Top.sv
// Combinational 4x4 unsigned Vedic multiplier built from four 2x2 blocks.
// The two cross products are summed first, then added in at weight 4.
module Vedic4x4_Top
    import vedic_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);

    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;
    logic [4:0] mid;

    assign q0  = vedic2x2(a[1:0], b[1:0]);
    assign q1  = vedic2x2(a[3:2], b[1:0]);
    assign q2  = vedic2x2(a[1:0], b[3:2]);
    assign q3  = vedic2x2(a[3:2], b[3:2]);
    assign mid = {1'b0, q1} + {1'b0, q2};

    // {q3,q0} places the high and low products; the crosswise sum sits at bit 2
    assign p   = {q3, q0} + {1'b0, mid, 2'b00};

endmodule

// File: rtl/vedic_mul8_seq.sv
// Iterative 8x8 multiplier: one 4x4 Vedic core reused over four CALC cycles,
// shifting and accumulating each nibble-pair product into a 16-bit sum.
// Valid/ready on both sides; outputs are decoded from registered state only.
// Optional build macro VEDIC_MUL8_SIGNED_EN: two's complement operands,
// magnitudes are multiplied and the sign is applied on the final step.
module vedic_mul8_seq
    import vedic_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLEAR_ON_POP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] product,
    output logic                busy
);

    if (DATA_W != 8) begin : g_bad_width
        $error("vedic_mul8_seq supports DATA_W == 8 only");
    end

    state_t              state_q;
    logic [1:0]          step_q;
    logic [7:0]          a_q;
    logic [7:0]          b_q;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   product_q;

    logic [7:0]          op_a;
    logic [7:0]          op_b;
    logic [NIB_W-1:0]    nib_a;
    logic [NIB_W-1:0]    nib_b;
    logic [2*NIB_W-1:0]  core_p;
    logic [3:0]          shift;
    logic [PROD_W-1:0]   addend;
    logic [PROD_W-1:0]   sum;
    logic [PROD_W-1:0]   final_val;

`ifdef VEDIC_MUL8_SIGNED_EN
    logic neg_q;
    logic neg_in;

    // Magnitudes are stored; |-128| = 0x80 still fits in 8 unsigned bits
    assign op_a      = a[7] ? (~a + 8'd1) : a;
    assign op_b      = b[7] ? (~b + 8'd1) : b;
    assign neg_in    = a[7] ^ b[7];
    assign final_val = neg_q ? (~sum + 16'd1) : sum;
`else
    assign op_a      = a;
    assign op_b      = b;
    assign final_val = sum;
`endif

    // Step bit 0 selects the high nibble of a, step bit 1 the high nibble of b
    assign nib_a  = step_q[0] ? a_q[7:4] : a_q[3:0];
    assign nib_b  = step_q[1] ? b_q[7:4] : b_q[3:0];
    assign shift  = SHIFT_TAB[{step_q, 2'b00} +: 4];
    assign addend = {8'd0, core_p} << shift;
    assign sum    = acc_q + addend;

    Vedic4x4_Top u_core (
        .a (nib_a),
        .b (nib_b),
        .p (core_p)
    );

    // FSM, operand capture, accumulation and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= 2'd0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            acc_q     <= '0;
            product_q <= '0;
`ifdef VEDIC_MUL8_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        acc_q   <= '0;
                        step_q  <= 2'd0;
                        state_q <= CALC;
`ifdef VEDIC_MUL8_SIGNED_EN
                        neg_q   <= neg_in;
`endif
                    end
                end
                CALC: begin
                    acc_q  <= sum;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        product_q <= final_val;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        if (CLEAR_ON_POP != 0) begin
                            product_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule
